// File: rtl/multiport_regfile.sv
// ============================================================================
// Module   : multiport_regfile
// Brief    : N-read / M-write register file with busy scoreboard; x0 is zero.
//            Optional same-cycle write-to-read bypass via REGFILE_BYPASS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multiport_regfile #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_READ      = 2,
  parameter int NUM_WRITE     = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_READ*ADDRESS_WIDTH-1:0] rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0]    rd_data,
  output logic [NUM_READ-1:0]               rd_busy,
  input  logic [NUM_WRITE-1:0]              wr_en,
  input  logic [NUM_WRITE*ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0]   wr_data,
  input  logic                              issue_en,
  input  logic [ADDRESS_WIDTH-1:0]          issue_addr,
  output logic [ADDRESS_WIDTH:0]            busy_count,
  output logic [DATA_WIDTH-1:0]             a0
);

  localparam int c_DEPTH  = 2**ADDRESS_WIDTH;
  localparam int c_A0_IDX = 10;

  logic [DATA_WIDTH-1:0]    r_mem [c_DEPTH];
  logic [c_DEPTH-1:0]       r_busy;
  logic [ADDRESS_WIDTH:0]   r_busy_count;
  logic [c_DEPTH-1:0]       w_busy_nxt;
  logic [ADDRESS_WIDTH:0]   w_cnt_nxt;
  logic [ADDRESS_WIDTH-1:0] w_wa [NUM_WRITE];
  logic [DATA_WIDTH-1:0]    w_wd [NUM_WRITE];

  for (genvar j = 0; j < NUM_WRITE; j++) begin : g_wr_unpack
    assign w_wa[j] = wr_addr[j*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign w_wd[j] = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
  end

  // Later ports overwrite earlier ones, giving highest-index priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < c_DEPTH; r++) begin
        r_mem[r] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (wr_en[j] && (w_wa[j] != '0)) begin
          r_mem[w_wa[j]] <= w_wd[j];
        end
      end
    end
  end

  // Issue is applied after writeback clears so a new producer stays outstanding.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int j = 0; j < NUM_WRITE; j++) begin
      if (wr_en[j]) begin
        w_busy_nxt[w_wa[j]] = 1'b0;
      end
    end
    if (issue_en) begin
      w_busy_nxt[issue_addr] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_comb begin
    w_cnt_nxt = '0;
    for (int r = 0; r < c_DEPTH; r++) begin
      w_cnt_nxt = w_cnt_nxt + (ADDRESS_WIDTH+1)'(w_busy_nxt[r]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy       <= '0;
      r_busy_count <= '0;
    end else begin
      r_busy       <= w_busy_nxt;
      r_busy_count <= w_cnt_nxt;
    end
  end

  assign busy_count = r_busy_count;
  assign a0         = r_mem[c_A0_IDX];

  for (genvar k = 0; k < NUM_READ; k++) begin : g_read
    logic [ADDRESS_WIDTH-1:0] w_ra;
    logic [DATA_WIDTH-1:0]    w_rd;
    logic                     w_rb;

    assign w_ra = rd_addr[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];

    always_comb begin
      w_rd = r_mem[w_ra];
      w_rb = r_busy[w_ra];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (wr_en[j] && (w_wa[j] == w_ra) && (w_ra != '0)) begin
          w_rd = w_wd[j];
          w_rb = 1'b0;
        end
      end
`endif
    end

    assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = w_rd;
    assign rd_busy[k]                          = w_rb;
  end

endmodule

`default_nettype wire

// File: tb/tb_multiport_regfile.sv
// ============================================================================
// Module   : tb_multiport_regfile
// Brief    : Vector-table and scoreboard bench for multiport_regfile.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_multiport_regfile;

  logic        clk;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic [5:0]  busy_count;
  logic [31:0] a0;

  int checks = 0;
  int errors = 0;

  multiport_regfile dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr), .busy_count(busy_count),
    .a0(a0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        ie;
    logic [4:0]  ia;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] ed0;
    logic [31:0] ed1;
    logic [1:0]  eb;
    logic [5:0]  ecnt;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];
  vec_t exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    wr_en      = v.we;
    wr_addr    = {v.wa1, v.wa0};
    wr_data    = {v.wd1, v.wd0};
    issue_en   = v.ie;
    issue_addr = v.ia;
    rd_addr    = {v.ra1, v.ra0};
  endtask

  task automatic idle();
    wr_en    = 2'b00;
    wr_addr  = '0;
    wr_data  = '0;
    issue_en = 1'b0;
    issue_addr = '0;
  endtask

  initial begin
    vec_t e;
    //          we     wa0   wd0            wa1   wd1           ie    ia    ra0   ra1   ed0            ed1            eb     ecnt
    vecs[0]  = '{2'b11, 5'd1, 32'h11111111, 5'd2, 32'h22222222, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0,         32'h0,         2'b00, 6'd0};
    vecs[1]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b1, 5'd1, 5'd1, 5'd2, 32'h11111111, 32'h22222222, 2'b00, 6'd1};
    vecs[2]  = '{2'b11, 5'd5, 32'h11,       5'd5, 32'h22,       1'b1, 5'd2, 5'd1, 5'd2, 32'h11111111, 32'h22222222, 2'b01, 6'd2};
    vecs[3]  = '{2'b01, 5'd0, 32'hDEADBEEF, 5'd0, 32'h0,        1'b1, 5'd0, 5'd5, 5'd2, 32'h22,       32'h22222222, 2'b10, 6'd2};
    vecs[4]  = '{2'b10, 5'd0, 32'h0,        5'd1, 32'h33,       1'b0, 5'd0, 5'd0, 5'd2, 32'h0,        32'h22222222, 2'b10, 6'd1};
    vecs[5]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b1, 5'd7, 5'd1, 5'd0, 32'h33,       32'h0,         2'b00, 6'd2};
    vecs[6]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b1, 5'd8, 5'd7, 5'd2, 32'h0,        32'h22222222, 2'b11, 6'd3};
    vecs[7]  = '{2'b01, 5'd7, 32'h77,       5'd0, 32'h0,        1'b0, 5'd0, 5'd8, 5'd5, 32'h0,        32'h22,        2'b01, 6'd2};
    vecs[8]  = '{2'b10, 5'd0, 32'h0,        5'd8, 32'h88,       1'b1, 5'd8, 5'd7, 5'd1, 32'h77,       32'h33,        2'b00, 6'd2};
    vecs[9]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0, 5'd8, 5'd2, 32'h88,       32'h22222222, 2'b11, 6'd2};
    vecs[10] = '{2'b11, 5'd2, 32'h2A,       5'd8, 32'h8A,       1'b0, 5'd0, 5'd1, 5'd7, 32'h33,       32'h77,        2'b00, 6'd0};
    vecs[11] = '{2'b00, 5'd1, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd2, 5'd8, 32'h2A,       32'h8A,        2'b00, 6'd0};
    vecs[12] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0, 5'd1, 5'd2, 32'h33,       32'h2A,        2'b00, 6'd0};

    rst = 1'b1;
    idle();
    rd_addr = {5'd2, 5'd1};
    #12;
    rst = 1'b0;
    #1;
    chk("reset_rd_data", rd_data[31:0], 32'h0);
    chk("reset_busy_count", 32'(busy_count), 32'h0);
    chk("reset_a0", a0, 32'h0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      exp_q.push_back(vecs[i]);
      #2;
      e = exp_q.pop_front();
      chk($sformatf("v%0d_rd0", i), rd_data[31:0], e.ed0);
      chk($sformatf("v%0d_rd1", i), rd_data[63:32], e.ed1);
      chk($sformatf("v%0d_busy", i), 32'(rd_busy), 32'(e.eb));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_cnt", i), 32'(busy_count), 32'(e.ecnt));
    end

    // a0 is raw stored x10: changes only after the edge
    @(negedge clk);
    idle();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd10}; wr_data = {32'h0, 32'hCAFE0001};
    #2;
    chk("a0_before_edge", a0, 32'h0);
    @(posedge clk);
    #1;
    chk("a0_after_edge", a0, 32'hCAFE0001);

    // bypass: x3=5 stored and busy, then write 9 while reading
    @(negedge clk);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'h5};
    @(negedge clk);
    idle();
    issue_en = 1'b1; issue_addr = 5'd3;
    @(negedge clk);
    idle();
    rd_addr = {5'd3, 5'd3};
    wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'h9};
    #2;
`ifdef REGFILE_BYPASS_EN
    chk("byp_rd_data", rd_data[31:0], 32'h9);
    chk("byp_rd_busy", 32'(rd_busy), 32'h0);
`else
    chk("nobyp_rd_data", rd_data[31:0], 32'h5);
    chk("nobyp_rd_busy", 32'(rd_busy), 32'h3);
`endif
    @(posedge clk);
    #1;
    chk("x3_after_rd_data", rd_data[63:32], 32'h9);
    chk("x3_after_rd_busy", 32'(rd_busy), 32'h0);
    chk("x3_after_cnt", 32'(busy_count), 32'h0);

    // both ports write x4 with a same-cycle issue of x4
    @(negedge clk);
    rd_addr = {5'd3, 5'd4};
    wr_en = 2'b11; wr_addr = {5'd4, 5'd4}; wr_data = {32'h41, 32'h40};
    issue_en = 1'b1; issue_addr = 5'd4;
    #2;
`ifdef REGFILE_BYPASS_EN
    chk("byp_prio_data", rd_data[31:0], 32'h41);
`else
    chk("nobyp_prio_data", rd_data[31:0], 32'h0);
`endif
    chk("issue_same_busy", 32'(rd_busy), 32'h0);
    @(negedge clk);
    idle();
    #1;
    chk("x4_data", rd_data[31:0], 32'h41);
    chk("x4_busy", 32'(rd_busy), 32'h1);
    chk("x4_cnt", 32'(busy_count), 32'h1);

    // async reset mid-cycle, with writes held across an edge during reset
    @(negedge clk);
    rd_addr = {5'd10, 5'd4};
    wr_en = 2'b11; wr_addr = {5'd2, 5'd1}; wr_data = {32'hFFFFFFFF, 32'hFFFFFFFF};
    issue_en = 1'b1; issue_addr = 5'd9;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_rd0", rd_data[31:0], 32'h0);
    chk("rst_rd1", rd_data[63:32], 32'h0);
    chk("rst_busy", 32'(rd_busy), 32'h0);
    chk("rst_cnt", 32'(busy_count), 32'h0);
    chk("rst_a0", a0, 32'h0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    rd_addr = {5'd2, 5'd1};
    idle();
    #1;
    chk("rst_discard_x1", rd_data[31:0], 32'h0);
    chk("rst_discard_x2", rd_data[63:32], 32'h0);
    chk("rst_discard_cnt", 32'(busy_count), 32'h0);

    @(negedge clk);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd6}; wr_data = {32'h0, 32'h66};
    issue_en = 1'b1; issue_addr = 5'd12;
    @(negedge clk);
    idle();
    rd_addr = {5'd12, 5'd6};
    #1;
    chk("post_rst_x6", rd_data[31:0], 32'h66);
    chk("post_rst_busy", 32'(rd_busy), 32'h2);
    chk("post_rst_cnt", 32'(busy_count), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multiport_regfile.md
# multiport_regfile

Parametrised successor to the single-write, two-read integer register file: N asynchronous read ports, M synchronous write ports with fixed priority, a per-register busy scoreboard for pipelined writeback, and optional same-cycle write-to-read bypass. Sits in the decode stage of the pipelined core. Decode reads operands and marks destinations busy at issue. Writeback (and a second writeback lane, e.g. load return) clears them. Register x0 is hardwired zero; x10 is exported as `a0` for the testbench display path.

## Interface
- `ADDRESS_WIDTH`, 5, register index width; depth = 2**ADDRESS_WIDTH.
- `DATA_WIDTH`, 32, register width.
- `NUM_READ`, 2, read ports (1..4).
- `NUM_WRITE`, 2, write ports (1..3).

- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: asynchronous, active-high; clears all registers and busy bits.
- `rd_addr` in NUM_READ*ADDRESS_WIDTH: packed read addresses, port k at slice k.
- `rd_data` out NUM_READ*DATA_WIDTH: packed read data.
- `rd_busy` out NUM_READ: busy bit of each addressed register.
- `wr_en` in NUM_WRITE: write enables.
- `wr_addr` in NUM_WRITE*ADDRESS_WIDTH: packed write addresses.
- `wr_data` in NUM_WRITE*DATA_WIDTH: packed write data.
- `issue_en` in 1: mark `issue_addr` busy.
- `issue_addr` in ADDRESS_WIDTH: destination being issued.
- `busy_count` out ADDRESS_WIDTH+1: number of busy registers.
- `a0` out DATA_WIDTH: contents of register 10.

## Operation
- Storage: 2**ADDRESS_WIDTH x DATA_WIDTH flops plus 2**ADDRESS_WIDTH busy bits. Entry 0 is never written and never busy; reads of x0 return 0, `rd_busy` 0.
- Write: on rising edge, for each port j with `wr_en[j]` and `wr_addr[j]!=0`, the register takes `wr_data[j]`. When several enabled ports target the same address, the highest index j wins.
- Any enabled write to address r clears busy[r].
- Issue: `issue_en` with `issue_addr!=0` sets busy[issue_addr]. A simultaneous write and issue to the same r leaves busy[r]=1, because issue takes priority (new producer outstanding). Issue to x0 is ignored.
- `busy_count` = popcount of busy bits. It is registered, updated on the same edge as the busy bits, and is range 0..2**ADDRESS_WIDTH-1.
- Reads are combinational from `rd_addr`. `rd_busy[k]` is busy[rd_addr[k]], subject to bypass (see Configuration).
- `a0` is the raw stored x10 and is never bypassed.

## Timing
- Read latency 0 (combinational). Write, busy set/clear and `busy_count` take effect at the next rising edge.
- Reset: asserting `rst` immediately forces all registers to 0, all busy bits to 0, `busy_count`=0, `a0`=0, `rd_data`=0 and `rd_busy`=0. Writes and issues in a cycle where `rst` is high are discarded. After deassertion, the first edge with `rst` low performs normal updates.
- Reset mid-operation discards outstanding busy state; no pending writes are retained.
- No handshake or back-pressure: every enabled write completes in one edge.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - A read port whose address matches an enabled write port this cycle (address != 0) returns that port's `wr_data`, using the highest-index matching port, and `rd_busy` for that port reads 0.
  - If `issue_en` targets the same address in the same cycle, `rd_busy` still reads 0. The read sees the value being written, and the issue affects only later cycles.
- Not defined:
  - `rd_data` and `rd_busy` reflect stored state only. A same-cycle write becomes visible after the edge.

## Test plan
- Reset: drive writes to all registers, assert `rst` between edges. Then `rd_data`=0 on all ports immediately, `busy_count`=0, `a0`=0.
- x0 protection: write 0xDEADBEEF to x0 and issue x0. Then reads of x0 return 0, `rd_busy`=0, `busy_count` unchanged.
- Write conflict: port0 writes x5=0x11 and port1 writes x5=0x22 on the same edge. Next cycle, reading x5 returns 0x22.
- Scoreboard: issue x7, then x8 on consecutive edges, giving `busy_count`=2. Write x7, giving `busy_count`=1. Issue x8 while writing x8 on the same edge: x8 remains busy and `busy_count`=1.
- Bypass, with macro defined: x3=0x5 stored and busy; write x3=0x9 while reading x3. Same cycle: `rd_data`=0x9, `rd_busy`=0. Without the macro: `rd_data`=0x5, `rd_busy`=1, then 0x9/0 after the edge.
- `a0`: write x10=0xCAFE0001. `a0` changes only after the edge, under either build.
